// File: rtl/msadc_if.sv
// Result handshake bundle for the multislope ADC sequencer.
// master: drives res_valid and the result fields; slave: drives res_ready.
interface msadc_if #(
  parameter int RUN_W = 15,
  parameter int RD_W  = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [RUN_W-1:0] res_runup_cnt;
  logic [RUN_W-1:0] res_runup_set;
  logic             res_sign;
  logic [RD_W-1:0]  res_rundown;
  logic             res_ovf;

  modport master (
    output res_valid,
    output res_runup_cnt,
    output res_runup_set,
    output res_sign,
    output res_rundown,
    output res_ovf,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_runup_cnt,
    input  res_runup_set,
    input  res_sign,
    input  res_rundown,
    input  res_ovf,
    output res_ready
  );
endinterface

// File: rtl/msadc_seq.sv
// Multislope integrating-ADC sequencer: reset, run-up, settle, run-down.
// Ports: mclk/rst_n, start/comp_in (async), runup_set, sw_* switches, res (msadc_if.master), busy, state_dbg.
module msadc_seq #(
  parameter int PRE_DIV   = 40,
  parameter int RUN_W     = 15,
  parameter int RD_W      = 16,
  parameter int PERIOD    = 100,
  parameter int MIN_PH    = 10,
  parameter int SETTLE    = 20,
  parameter int RD_MAX    = 1200,
  parameter int RST_TICKS = 4000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp_in,
  input  logic [RUN_W-1:0] runup_set,
  output logic             sw_rst,
  output logic             sw_in,
  output logic             sw_vref,
  output logic             sw_up,
  output logic             sw_dn,
  msadc_if.master          res,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUNUP = 3'd2;
  localparam logic [2:0] S_SETTL = 3'd3;
  localparam logic [2:0] S_RDOWN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int DIV_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic             start_s1_q, start_s_q;
  logic             comp_s1_q, comp_s_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  logic [2:0]       state_q, state_d;
  logic [31:0]      ph_q, ph_d;
  logic [31:0]      cph_q, cph_d;
  logic [RUN_W-1:0] cyc_q, cyc_d;
  logic [RUN_W-1:0] set_q, set_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             sign_q, sign_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             gate_q, gate_d;
  logic             ovf_q, ovf_d;
  logic             load;

  logic             valid_q, valid_d;
  logic [RUN_W-1:0] r_cnt_q, r_set_q;
  logic             r_sign_q, r_ovf_q;
  logic [RD_W-1:0]  r_rd_q;

  logic sw_rst_d, sw_in_d, sw_vref_d, sw_up_d, sw_dn_d;
  logic sw_rst_q, sw_in_q, sw_vref_q, sw_up_q, sw_dn_q;

  assign tick = (div_q == DIV_W'(PRE_DIV - 1));

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1_q <= 1'b0;
      start_s_q  <= 1'b0;
      comp_s1_q  <= 1'b0;
      comp_s_q   <= 1'b0;
      div_q      <= '0;
    end else begin
      start_s1_q <= start;
      start_s_q  <= start_s1_q;
      comp_s1_q  <= comp_in;
      comp_s_q   <= comp_s1_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cph_d   = cph_q;
    cyc_d   = cyc_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    sign_d  = sign_q;
    rd_d    = rd_q;
    gate_d  = gate_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s_q) begin
          state_d = S_RESET;
          ph_d    = '0;
        end
      end
      S_RESET: begin
        if (!start_s_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (ph_q == 32'(RST_TICKS - 1)) begin
            state_d = S_RUNUP;
            set_d   = runup_set;
            cnt_d   = '0;
            cyc_d   = '0;
            cph_d   = '0;
            dec_d   = 1'b0;
          end else begin
            ph_d = ph_q + 32'd1;
          end
        end
      end
      S_RUNUP: begin
        if (!start_s_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (cph_q == 32'(PERIOD - 1)) begin
            cph_d = '0;
            // final cycle's comparator sample is deliberately dropped
            if (cyc_q == set_q) begin
              state_d = S_SETTL;
              ph_d    = '0;
            end else begin
              cyc_d = cyc_q + RUN_W'(1);
              dec_d = comp_s_q;
              cnt_d = cnt_q + RUN_W'(comp_s_q);
            end
          end else begin
            cph_d = cph_q + 32'd1;
          end
        end
      end
      S_SETTL: begin
        if (!start_s_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (ph_q == 32'(SETTLE - 1)) begin
            state_d = S_RDOWN;
            sign_d  = comp_s_q;
            ph_d    = '0;
            rd_d    = '0;
            gate_d  = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            ph_d = ph_q + 32'd1;
          end
        end
      end
      S_RDOWN: begin
        if (!start_s_q) begin
          state_d = S_IDLE;
        end else begin
          if (gate_q) begin
            if (comp_s_q != sign_q) gate_d = 1'b0;
            else if (&rd_q)         ovf_d  = 1'b1;
            else                    rd_d   = rd_q + RD_W'(1);
          end
          if (tick) begin
            if (ph_q == 32'(RD_MAX - 1)) begin
              ovf_d   = ovf_d | gate_d;
              state_d = S_DONE;
            end else begin
              ph_d = ph_q + 32'd1;
            end
          end
        end
      end
      S_DONE: begin
        // park here under backpressure; never overwrite an unread result
        if (!valid_q || res.res_ready) begin
          load    = 1'b1;
          state_d = start_s_q ? S_RESET : S_IDLE;
          ph_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (load)                        valid_d = 1'b1;
    else if (valid_q && res.res_ready) valid_d = 1'b0;
  end

  // switches follow the next state so they line up with state_q
  always_comb begin
    sw_rst_d  = 1'b0;
    sw_in_d   = 1'b0;
    sw_vref_d = 1'b0;
    sw_up_d   = 1'b0;
    sw_dn_d   = 1'b0;
    case (state_d)
      S_RUNUP: begin
        sw_in_d   = 1'b1;
        sw_vref_d = 1'b1;
        sw_dn_d   = dec_d ? (cph_d < 32'(MIN_PH))
                          : (cph_d < 32'(PERIOD - MIN_PH));
        sw_up_d   = !sw_dn_d;
      end
      S_SETTL: ;
      S_RDOWN: begin
        sw_up_d = sign_d;
        sw_dn_d = !sign_d;
      end
      default: begin
        sw_rst_d  = 1'b1;
        sw_vref_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      cph_q    <= '0;
      cyc_q    <= '0;
      set_q    <= '0;
      cnt_q    <= '0;
      dec_q    <= 1'b0;
      sign_q   <= 1'b0;
      rd_q     <= '0;
      gate_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      r_cnt_q  <= '0;
      r_set_q  <= '0;
      r_sign_q <= 1'b0;
      r_rd_q   <= '0;
      r_ovf_q  <= 1'b0;
      sw_rst_q  <= 1'b1;
      sw_in_q   <= 1'b0;
      sw_vref_q <= 1'b1;
      sw_up_q   <= 1'b0;
      sw_dn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cph_q   <= cph_d;
      cyc_q   <= cyc_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      gate_q  <= gate_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      if (load) begin
        r_cnt_q  <= cnt_q;
        r_set_q  <= set_q;
        r_sign_q <= sign_q;
        r_rd_q   <= rd_q;
        r_ovf_q  <= ovf_q;
      end
      sw_rst_q  <= sw_rst_d;
      sw_in_q   <= sw_in_d;
      sw_vref_q <= sw_vref_d;
      sw_up_q   <= sw_up_d;
      sw_dn_q   <= sw_dn_d;
    end
  end

  assign sw_rst  = sw_rst_q;
  assign sw_in   = sw_in_q;
  assign sw_vref = sw_vref_q;
  assign sw_up   = sw_up_q;
  assign sw_dn   = sw_dn_q;

  assign res.res_valid     = valid_q;
  assign res.res_runup_cnt = r_cnt_q;
  assign res.res_runup_set = r_set_q;
  assign res.res_sign      = r_sign_q;
  assign res.res_rundown   = r_rd_q;
  assign res.res_ovf       = r_ovf_q;

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
